hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EX/MEM/WB destination slots, drives the EX
// forwarding muxes and the stall/flush/bubble controls for IF and ID.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [4:0] ID_waddr,
    input  logic       ID_regwrite,
    input  logic       ID_memread,
    input  logic       ID_useb,
    input  logic       branch_taken,
    input  logic       hold,
    output logic [1:0] EX_forward1,
    output logic [1:0] EX_forward2,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       bubble_ex
);

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic [4:0] waddr;
    } slot_t;

    localparam logic [1:0] FWD_RDATA = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;

    slot_t      ex_q;
    slot_t      mem_q;
    slot_t      wb_q;
    logic [4:0] ex_rs_q;
    logic [4:0] ex_rt_q;

    logic load_use;
    logic branch_dep;
    logic stall;

    // Register 0 is hardwired, so a write to it never produces a usable result.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.regwrite && (s.waddr == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                           input logic [4:0] r);
        if (slot_hit(m, r))
            return FWD_MEM;
        else if (slot_hit(w, r))
            return FWD_WB;
        else
            return FWD_RDATA;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else if (!hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble_ex) begin
                ex_q    <= '0;
                ex_rs_q <= '0;
                ex_rt_q <= '0;
            end else begin
                ex_q    <= '{regwrite: ID_regwrite, memread: ID_memread, waddr: ID_waddr};
                ex_rs_q <= ID_rs;
                ex_rt_q <= ID_rt;
            end
        end
    end

    always_comb begin
        EX_forward1 = fwd_sel(mem_q, wb_q, ex_rs_q);
        EX_forward2 = fwd_sel(mem_q, wb_q, ex_rt_q);

        load_use = ex_q.memread && (slot_hit(ex_q, ID_rs) || slot_hit(ex_q, ID_rt));

        // Branches compare in ID, so an EX result or a load still in MEM is too late.
        branch_dep = ID_useb &&
                     (slot_hit(ex_q, ID_rs) || slot_hit(ex_q, ID_rt) ||
                      (mem_q.memread && (slot_hit(mem_q, ID_rs) || slot_hit(mem_q, ID_rt))));

        stall = load_use || branch_dep;
    end

    assign stall_if  = stall | hold;
    assign stall_id  = stall | hold;
    assign bubble_ex = stall & ~hold;
    assign flush_id  = branch_taken & ~stall & ~hold;

endmodule
